dm_cache_unit: RTL and testbench



---
 rtl/dm_cache_pkg.sv | 54 +++++
 rtl/dm_cache_line_store.sv | 55 +++++
 rtl/dm_cache_unit.sv | 215 +++++++++++++++++++++
 tb/tb_dm_cache_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared types and helpers for the direct-mapped cache unit.
// FSM state encoding, field-width helpers and address field extraction.
package dm_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(
        input int addr_w,
        input int line_words,
        input int num_lines
    );
        return addr_w - off_w(line_words) - idx_w(num_lines);
    endfunction

    // Extractors work on a zero-extended 32-bit address; callers size-cast.
    function automatic logic [31:0] addr_off(
        input logic [31:0] a,
        input int          ow
    );
        return a & ((32'd1 << ow) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(
        input logic [31:0] a,
        input int          ow,
        input int          iw
    );
        return (a >> ow) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(
        input logic [31:0] a,
        input int          ow,
        input int          iw
    );
        return a >> (ow + iw);
    endfunction

endpackage

// File: rtl/dm_cache_line_store.sv
// dm_cache_line_store: valid/tag/data arrays of the direct-mapped cache.
// Combinational read; synchronous word/tag write; async clear of valid bits.
module dm_cache_line_store
    import dm_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10,
    parameter int OFF_W  = 2,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [OFF_W-1:0]  i_roff,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_word,
    input  logic              i_word_we,
    input  logic [OFF_W-1:0]  i_woff,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_tag_we,
    input  logic [TAG_W-1:0]  i_wtag
);

    localparam int LINES = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES][WORDS];

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_word  = r_data[i_idx][i_roff];

    // A line becomes valid only when its tag is written (last refill beat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Data and tag arrays are never cleared; valid bits guard them.
    always_ff @(posedge clk) begin
        if (i_word_we) begin
            r_data[i_idx][i_woff] <= i_wdata;
        end
        if (i_tag_we) begin
            r_tag[i_idx] <= i_wtag;
        end
    end

endmodule

// File: rtl/dm_cache_unit.sv
// dm_cache_unit: direct-mapped read-allocate, write-through/no-allocate cache.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache_unit
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_hit;
    logic [OFF_W-1:0]    r_beat;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [OFF_W-1:0]    w_off;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [DATA_W-1:0]   w_line_word;
    logic                w_hit;
    logic                w_beat;
    logic                w_last;
    logic                w_word_we;
    logic [OFF_W-1:0]    w_woff;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_tag_we;

    assign w_off = OFF_W'(addr_off(32'(r_addr), OFF_W));
    assign w_idx = IDX_W'(addr_idx(32'(r_addr), OFF_W, IDX_W));
    assign w_tag = TAG_W'(addr_tag(32'(r_addr), OFF_W, IDX_W));

    assign w_hit  = w_line_valid && (w_line_tag == w_tag);
    assign w_beat = (r_state == S_REFILL) && mem_rsp_valid;
    assign w_last = (r_beat == OFF_W'(LINE_WORDS - 1));

    // Store write port: refill beats, or a write hit patched in LOOKUP.
    always_comb begin
        w_word_we = 1'b0;
        w_woff    = w_off;
        w_wdata   = r_wdata;
        w_tag_we  = 1'b0;
        if (w_beat) begin
            w_word_we = 1'b1;
            w_woff    = r_beat;
            w_wdata   = mem_rsp_data;
            w_tag_we  = w_last;
        end else if (r_state == S_LOOKUP && r_we && w_hit) begin
            w_word_we = 1'b1;
        end
    end

    dm_cache_line_store #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_idx     (w_idx),
        .i_roff    (w_off),
        .o_valid   (w_line_valid),
        .o_tag     (w_line_tag),
        .o_word    (w_line_word),
        .i_word_we (w_word_we),
        .i_woff    (w_woff),
        .i_wdata   (w_wdata),
        .i_tag_we  (w_tag_we),
        .i_wtag    (w_tag)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we)       w_next = S_WRITE;
                else if (w_hit) w_next = S_RESP;
                else            w_next = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                if (mem_req_ready) w_next = S_REFILL;
            end
            S_REFILL: begin
                if (w_beat && w_last) w_next = S_RESP;
            end
            S_WRITE: begin
                if (mem_req_ready) w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; IDLE decodes to the reset values.
    always_comb begin
        req_ready     = (r_state == S_IDLE);
        rsp_valid     = (r_state == S_RESP);
        rsp_rdata     = '0;
        rsp_hit       = (r_state == S_RESP) && r_hit;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        if (r_state == S_RESP && !r_we) begin
            rsp_rdata = w_line_word;
        end
        if (r_state == S_REFILL_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
        end
        if (r_state == S_WRITE) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = r_addr;
            mem_wdata     = r_wdata;
        end
    end

    // Request latch, lookup verdict and refill beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_beat  <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            if (r_state == S_LOOKUP) begin
                r_hit <= w_hit;
            end
            if (w_beat) begin
                r_beat <= r_beat + OFF_W'(1);
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating hit/miss counters, stepped once per lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dm_cache_unit.sv
// tb_dm_cache_unit: directed self-checking bench for dm_cache_unit.
// Memory side is driven by hand; CACHE_STATS_EN adds the counter checks.
module tb_dm_cache_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [14:0] mem_req_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_cache_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_hit       (rsp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_hit"}, 32'(rsp_hit), 32'd0);
        chk({tag, "_mem_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_req_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_req_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Read transaction; on a miss, serve a line of beats b0..b0+3.
    task automatic read_txn(
        input logic [14:0] a,
        input bit          miss,
        input logic [14:0] base,
        input logic [31:0] b0,
        input int          dly,
        input logic [31:0] exp_d
    );
        chk("rd_accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        chk("rd_lookup_ready", 32'(req_ready), 32'd0);
        chk("rd_lookup_memv", 32'(mem_req_valid), 32'd0);
        chk("rd_lookup_rspv", 32'(rsp_valid), 32'd0);
        step();
        if (miss) begin
            for (int i = 0; i <= dly; i++) begin
                chk("rf_memv", 32'(mem_req_valid), 32'd1);
                chk("rf_mem_we", 32'(mem_req_we), 32'd0);
                chk("rf_mem_addr", 32'(mem_req_addr), 32'(base));
                if (i < dly) step();
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk("rf_memv_drop", 32'(mem_req_valid), 32'd0);
            for (int i = 0; i < 4; i++) begin
                chk("rf_no_rsp", 32'(rsp_valid), 32'd0);
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = b0 + 32'(i);
                step();
            end
            mem_rsp_valid = 1'b0;
        end
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, exp_d);
        chk("rd_rsp_hit", 32'(rsp_hit), miss ? 32'd0 : 32'd1);
        chk("rd_rsp_memv", 32'(mem_req_valid), 32'd0);
        step();
        chk("rd_after_rspv", 32'(rsp_valid), 32'd0);
        chk("rd_after_ready", 32'(req_ready), 32'd1);
    endtask

    // Write-through transaction; ready held off for dly cycles.
    task automatic write_txn(
        input logic [14:0] a,
        input logic [31:0] d,
        input int          dly,
        input bit          exp_hit
    );
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        chk("wr_lookup_memv", 32'(mem_req_valid), 32'd0);
        step();
        for (int i = 0; i <= dly; i++) begin
            chk("wr_memv", 32'(mem_req_valid), 32'd1);
            chk("wr_mem_we", 32'(mem_req_we), 32'd1);
            chk("wr_mem_addr", 32'(mem_req_addr), 32'(a));
            chk("wr_mem_wdata", mem_wdata, d);
            chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
            if (i < dly) step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_hit", 32'(rsp_hit), exp_hit ? 32'd1 : 32'd0);
        chk("wr_rsp_memv", 32'(mem_req_valid), 32'd0);
        step();
        chk("wr_after_rspv", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        step();
        step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Cold miss: line 0x0004 refilled with A0..A3, offset 1 returned.
        read_txn(15'h0005, 1'b1, 15'h0004, 32'hA0, 0, 32'hA1);
        // Same line now hits.
        read_txn(15'h0006, 1'b0, 15'h0000, 32'h0, 0, 32'hA2);
        // Write hit with ready delayed 3 cycles, then read it back.
        write_txn(15'h0006, 32'hDEAD, 3, 1'b1);
        read_txn(15'h0006, 1'b0, 15'h0000, 32'h0, 0, 32'hDEAD);
        // Conflict: same index, other tag evicts, then original misses.
        read_txn(15'h1004, 1'b1, 15'h1004, 32'hB0, 1, 32'hB0);
        read_txn(15'h0004, 1'b1, 15'h0004, 32'hC0, 0, 32'hC0);
        read_txn(15'h0007, 1'b0, 15'h0000, 32'h0, 0, 32'hC3);
        // Write miss goes to memory only; the line is not allocated.
        write_txn(15'h2000, 32'h1234, 0, 1'b0);
        read_txn(15'h2000, 1'b1, 15'h2000, 32'hD0, 0, 32'hD0);

        // Reset in the middle of a refill, after two beats.
        req_valid = 1'b1;
        req_addr  = 15'h0009;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_refill_req", 32'(mem_req_addr), 32'h0008);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hE0 + 32'(i);
            step();
        end
        mem_rsp_data = 32'hE2;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        step();
        rst_n        = 1'b1;
        mem_rsp_data = 32'hE3;
        step();
        mem_rsp_valid = 1'b0;
        chk_idle_outputs("postrst");
        step();
        read_txn(15'h0009, 1'b1, 15'h0008, 32'hF0, 2, 32'hF1);
        read_txn(15'h0004, 1'b1, 15'h0004, 32'h60, 0, 32'h60);

`ifdef CACHE_STATS_EN
        force dut.r_hit_cnt  = 32'hFFFF_FFFE;
        force dut.r_miss_cnt = 32'd0;
        #1;
        release dut.r_hit_cnt;
        release dut.r_miss_cnt;
        chk("stat_hit_preload", hit_count, 32'hFFFF_FFFE);
        read_txn(15'h0008, 1'b0, 15'h0000, 32'h0, 0, 32'hF0);
        chk("stat_hit_step", hit_count, 32'hFFFF_FFFF);
        read_txn(15'h000A, 1'b0, 15'h0000, 32'h0, 0, 32'hF2);
        read_txn(15'h000B, 1'b0, 15'h0000, 32'h0, 0, 32'hF3);
        chk("stat_hit_sat", hit_count, 32'hFFFF_FFFF);
        read_txn(15'h3008, 1'b1, 15'h3008, 32'h50, 0, 32'h50);
        write_txn(15'h3009, 32'h77, 0, 1'b1);
        chk("stat_miss", miss_count, 32'd1);
        chk("stat_hit_final", hit_count, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
